// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - control sequencer for a CIC decimator (integrator/comb enables, output handshake).
// Optional macro CIC_CTRL_OVF_HALT_EN: integrator overflow halts processing until enable drops.
module cic_decim_ctrl #(
  parameter int N_STAGES = 3,
  parameter int RATE_W   = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic [RATE_W-1:0]   rate,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                integ_en,
  output logic                comb_en,
  output logic                out_load,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                dp_clr,
  input  logic [N_STAGES-1:0] ovf_in,
  output logic                ovf_sticky,
  output logic                busy
);

  localparam int PC_W = $clog2(N_STAGES + 1);

`ifdef CIC_CTRL_OVF_HALT_EN
  typedef enum logic [1:0] {IDLE, PRIME, RUN, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
`endif

  state_t              state, state_nxt;
  logic [RATE_W-1:0]   rate_q;
  logic [RATE_W-1:0]   phase;
  logic [PC_W-1:0]     prime_cnt;
  logic [N_STAGES-1:0] tag_pipe;
  logic                active;
  logic                last_phase;
  logic                ovf_any;
  logic                tag;

  assign active     = (state == PRIME) || (state == RUN);
  assign last_phase = (phase == rate_q - RATE_W'(1));
  assign ovf_any    = |ovf_in;
  assign busy       = (state != IDLE);

  always_comb begin
    in_ready = 1'b0;
    integ_en = 1'b0;
    comb_en  = 1'b0;
    out_load = 1'b0;
    tag      = 1'b0;
    dp_clr   = (state == IDLE) && enable;
    if (active) begin
      // A pending output that downstream has not taken blocks new samples.
      in_ready = !(out_valid && !out_ready);
      integ_en = in_valid && in_ready;
      tag      = integ_en && last_phase;
      comb_en  = integ_en && tag_pipe[N_STAGES-1];
      out_load = comb_en && (state == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (enable) state_nxt = PRIME;
    end else if (!enable) begin
      state_nxt = IDLE;
`ifdef CIC_CTRL_OVF_HALT_EN
    end else if (active && ovf_any) begin
      state_nxt = HALT;
`endif
    end else if ((state == PRIME) && comb_en && (prime_cnt == PC_W'(N_STAGES - 1))) begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rate_q     <= RATE_W'(1);
      phase      <= '0;
      prime_cnt  <= '0;
      tag_pipe   <= '0;
      out_valid  <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (enable) begin
          rate_q     <= (rate == '0) ? RATE_W'(1) : rate;
          ovf_sticky <= 1'b0;
        end
        phase     <= '0;
        prime_cnt <= '0;
        tag_pipe  <= '0;
        out_valid <= 1'b0;
      end else if (!enable) begin
        phase     <= '0;
        prime_cnt <= '0;
        tag_pipe  <= '0;
        out_valid <= 1'b0;
      end else begin
        if (integ_en) begin
          phase    <= last_phase ? '0 : phase + RATE_W'(1);
          tag_pipe <= (tag_pipe << 1) | N_STAGES'(tag);
        end
        if ((state == PRIME) && comb_en) prime_cnt <= prime_cnt + PC_W'(1);
        if (out_load) out_valid <= 1'b1;
        else if (out_valid && out_ready) out_valid <= 1'b0;
      end
      if (active && ovf_any) ovf_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb/tb_cic_decim_ctrl.sv - scoreboard bench for cic_decim_ctrl against an accept-count reference model.
module tb_cic_decim_ctrl;

  localparam int N  = 3;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          enable = 1'b0;
  logic [RW-1:0] rate = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [N-1:0]  ovf_in = '0;
  logic          in_ready, integ_en, comb_en, out_load, out_valid, dp_clr, ovf_sticky, busy;

  always #5 clk = ~clk;

  cic_decim_ctrl #(.N_STAGES(N), .RATE_W(RW)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .rate(rate),
    .in_valid(in_valid), .in_ready(in_ready), .integ_en(integ_en),
    .comb_en(comb_en), .out_load(out_load), .out_valid(out_valid),
    .out_ready(out_ready), .dp_clr(dp_clr), .ovf_in(ovf_in),
    .ovf_sticky(ovf_sticky), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  // Reference model: everything follows from the accept count since start.
  bit m_active = 0, m_halt = 0, m_ov = 0, m_sticky = 0;
  int m_r = 1, m_k = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit iv, input bit ordy, input bit en, input int rt, input logic [N-1:0] ov);
    bit exp_rdy, acc, comb, load;
    @(posedge clk);
    #1;
    in_valid = iv; out_ready = ordy; enable = en; rate = RW'(rt); ovf_in = ov;
    @(negedge clk);
    exp_rdy = m_active && !m_halt && !(m_ov && !ordy);
    acc = iv && exp_rdy;
    if (acc) m_k++;
    comb = acc && (m_k > N) && (((m_k - N) % m_r) == 0);
    load = comb && (((m_k - N) / m_r) > N);
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    chk("integ_en", int'(integ_en), int'(acc));
    chk("comb_en", int'(comb_en), int'(comb));
    chk("out_load", int'(out_load), int'(load));
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("busy", int'(busy), int'(m_active));
    chk("dp_clr", int'(dp_clr), int'(!m_active && en));
    chk("ovf_sticky", int'(ovf_sticky), int'(m_sticky));
    if (load && en) exp_q.push_back(m_k);
    if (!m_active) begin
      if (en) begin
        m_active = 1; m_halt = 0; m_ov = 0; m_sticky = 0; m_k = 0;
        m_r = (rt == 0) ? 1 : rt;
      end
    end else if (!en) begin
      m_active = 0; m_halt = 0; m_ov = 0; m_k = 0;
      if (|ov) m_sticky = 1;
    end else begin
      if (load) m_ov = 1;
      else if (m_ov && ordy) m_ov = 0;
      if (|ov) begin
        m_sticky = 1;
`ifdef CIC_CTRL_OVF_HALT_EN
        m_halt = 1;
`endif
      end
    end
  endtask

  task automatic run_until_ov(input int rt, input int bound);
    int n = 0;
    while (!m_ov && n < bound) begin
      step(1, 1, 1, rt, '0);
      n++;
    end
    if (!m_ov) chk("wait_out_valid_timeout", 0, 1);
  endtask

  // Monitor: matches each output handshake to the accept index that loaded it.
  int dut_cnt = 0;
  int pend = 0;
  always @(negedge clk) begin
    if (!busy) begin
      dut_cnt = 0;
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", pend, -1);
        else chk("output_accept_idx", pend, exp_q.pop_front());
      end
      if (integ_en) dut_cnt++;
      if (out_load) pend = dut_cnt;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_ovf_sticky", int'(ovf_sticky), 0);
    chk("rst_dp_clr", int'(dp_clr), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Continuous flow at R=4, then a 5-cycle output stall.
    step(0, 1, 1, 4, '0);
    repeat (30) step(1, 1, 1, 4, '0);
    run_until_ov(4, 40);
    repeat (5) step(1, 0, 1, 4, '0);
    step(1, 1, 1, 4, '0);
    repeat (10) step(1, 1, 1, 4, '0);

    // Overflow pulse in RUN, then continue.
    step(1, 1, 1, 4, 3'b010);
    repeat (12) step(1, 1, 1, 4, '0);

    // Abort with a pending output, restart at R=2.
    run_until_ov(4, 40);
    step(1, 0, 0, 4, '0);
    step(0, 1, 0, 4, '0);
    step(0, 1, 1, 2, '0);
    repeat (30) step(1, 1, 1, 2, '0);

    // R=0 behaves as R=1.
    step(0, 1, 0, 0, '0);
    step(0, 1, 1, 0, '0);
    repeat (15) step(1, 1, 1, 0, '0);

    // Asynchronous reset mid-run with out_valid high and sticky set.
    step(1, 1, 1, 0, 3'b001);
    run_until_ov(0, 20);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_in_ready", int'(in_ready), 0);
    chk("async_ovf_sticky", int'(ovf_sticky), 0);
    enable = 1'b0;
    m_active = 0; m_halt = 0; m_ov = 0; m_k = 0; m_sticky = 0;
    @(negedge clk);
    rstn = 1'b1;
    step(0, 1, 1, 3, '0);
    repeat (20) step(1, 1, 1, 3, '0);
    step(0, 1, 0, 3, '0);

    // Randomized episodes.
    for (int e = 0; e < 8; e++) begin
      int rt;
      int len;
      rt  = $urandom_range(0, 5);
      len = $urandom_range(60, 120);
      step(0, 1, 1, rt, '0);
      for (int c = 0; c < len; c++) begin
        logic [N-1:0] ov;
        ov = ($urandom_range(0, 59) == 0) ? N'($urandom_range(1, 7)) : '0;
        step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, 1, rt, ov);
      end
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, rt, '0);
      step(0, 1, 0, rt, '0);
    end

    // Final run to drain the scoreboard.
    step(0, 1, 1, 1, '0);
    repeat (12) step(1, 1, 1, 1, '0);
    repeat (3) step(0, 1, 1, 1, '0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cic_decim_ctrl.md
Name: cic_decim_ctrl

Overview:
Control sequencer for the CIC decimator datapath (integrator chain, comb chain, output register).
- Accepts the input sample stream with a valid/ready handshake and issues the integrator chain enable.
- Counts samples to the runtime decimation rate, schedules comb-chain enables and suppresses outputs until the comb chain is primed.
- Drives the output valid/ready handshake and stalls the input while output is backpressured.
- Aggregates integrator overflow flags.

Parameters:
N_STAGES, 3, number of integrator/comb stages; also the tag-pipeline depth and the prime count
RATE_W, 8, width of the decimation-rate input

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
enable  input  1  level; 1 = run, 0 = abort to IDLE
rate  input  RATE_W  decimation ratio R; sampled only on the IDLE->PRIME transition
in_valid  input  1  input sample valid
in_ready  output  1  controller can accept a sample
integ_en  output  1  integrator chain clock enable
comb_en  output  1  comb chain clock enable
out_load  output  1  load the datapath output register
out_valid  output  1  decimated output valid
out_ready  input  1  downstream accepts output
dp_clr  output  1  one-cycle synchronous clear of datapath registers
ovf_in  input  N_STAGES  per-integrator overflow flags
ovf_sticky  output  1  sticky overflow status
busy  output  1  state != IDLE

Behaviour:
- Reset: state=IDLE; all counters and the tag pipeline cleared; out_valid, dp_clr and ovf_sticky = 0.
- Combinational outputs: in_ready, integ_en, comb_en and out_load are 0 whenever state=IDLE.
- States: IDLE, PRIME, RUN, HALT. HALT exists only with the optional feature.
- IDLE->PRIME when enable=1:
  - rate_q <= rate; a rate of 0 is stored as 1.
  - dp_clr=1 for exactly that cycle.
  - ovf_sticky cleared.
- Any non-IDLE state with enable=0: next state IDLE.
  - out_valid, phase, prime_cnt and tag pipeline cleared next clock.
  - A pending output is dropped.
  - No dp_clr pulse on this transition.
- in_ready = (state is PRIME or RUN) and not (out_valid and not out_ready). Combinational.
- accept = in_valid and in_ready. integ_en = accept, combinational, same cycle.
- phase counter runs 0..rate_q-1 and increments on accept, wrapping to 0.
- tag = accept and (phase == rate_q-1).
- Tag pipeline is N_STAGES bits deep and shifts only on integ_en, with tag entering bit 0.
  - comb_en = integ_en and bit N_STAGES-1, i.e. the comb enable coincides with the accept N_STAGES samples after the tagged sample.
- Priming:
  - prime_cnt counts comb_en pulses in PRIME.
  - The N_STAGES-th pulse moves PRIME->RUN; no out_load is issued for these pulses.
- RUN: out_load = comb_en.
- out_valid:
  - Set the clock after out_load.
  - Cleared the clock after (out_valid and out_ready).
  - If a load and a handshake occur in the same cycle, out_valid stays 1.
  - A load cannot occur while out_valid and not out_ready, because in_ready=0 blocks accepts.
- Overflow: ovf_sticky <= 1 when state is PRIME or RUN and ovf_in is nonzero. It holds until the next dp_clr.
- Simultaneous events:
  - enable=0 has priority over every in-cycle event; an accept in that same cycle is still reported on integ_en.
- The rate input is ignored outside IDLE. Changing R requires enable low for at least 1 cycle.

Optional Feature:
Macro CIC_CTRL_OVF_HALT_EN.
- Defined: a nonzero ovf_in while in PRIME or RUN moves the state to HALT on the next clock.
  - In HALT, in_ready, integ_en, comb_en and out_load are 0; out_valid still completes its handshake; busy=1; ovf_sticky=1.
  - HALT exits only via enable=0 -> IDLE.
- Not defined: HALT is absent; overflow only sets ovf_sticky and processing continues.

Test Plan:
- Reset: assert rstn=0 mid-run with out_valid=1 -> out_valid, in_ready, busy, ovf_sticky all 0 immediately (asynchronous); enable=1 after release -> dp_clr one cycle.
- N_STAGES=3, rate=4, in_valid=1, out_ready=1 continuously -> tags on accepts 4,8,12...; comb_en on accepts 7,11,15 (priming, no out_load); first out_load on accept 19; out_valid=1 the next cycle; then one output per 4 accepts.
- Same setup, out_ready=0 when out_valid rises -> in_ready=0, integ_en=0 and phase frozen for 5 cycles; out_ready=1 for one cycle -> out_valid falls and in_ready=1 the same cycle.
- rate=0 (treated as 1) -> comb_en on accepts 4,5,6 priming; out_load on every accept from 7.
- enable=0 while out_valid=1 in RUN -> next cycle state IDLE, out_valid=0, busy=0; enable=1 with rate=2 -> new dp_clr and priming restarts from prime_cnt=0.
- ovf_in=3'b010 for one cycle in RUN:
  - Without the macro: ovf_sticky=1 and held, outputs continue; cleared at next dp_clr.
  - With CIC_CTRL_OVF_HALT_EN: next cycle HALT, in_ready=0, busy=1.
